fifo_burst_reader: RTL and testbench

//  Read-side master for the synchronous FIFO (fifotest): pops a programmed burst of words from the

---
 rtl/fifo_burst_reader_if.sv | 33 +++
 rtl/fifo_burst_reader.sv | 133 +++++++++++++
 tb/tb_fifo_burst_reader.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_reader_if.sv
// Read-side bundle of the burst reader: FIFO pop port plus
// the valid/ready output stream.
interface fifo_burst_reader_if #(
   parameter int WIDTH = 8
);
   logic             rd_en_o;
   logic [WIDTH-1:0] rdata_i;
   logic             empty_i;
   logic             rd_error_i;
   logic [WIDTH-1:0] out_data_o;
   logic             out_valid_o;
   logic             out_ready_i;

   modport master (
      output rd_en_o,
      input  rdata_i,
      input  empty_i,
      input  rd_error_i,
      output out_data_o,
      output out_valid_o,
      input  out_ready_i
   );

   modport slave (
      input  rd_en_o,
      output rdata_i,
      output empty_i,
      output rd_error_i,
      input  out_data_o,
      input  out_valid_o,
      output out_ready_i
   );
endinterface

// File: rtl/fifo_burst_reader.sv
// Burst reader: pops a programmed number of words from the FIFO
// and streams them out through a 2-entry skid buffer.
module fifo_burst_reader #(
   parameter int WIDTH     = 8,
   parameter int LEN_WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [LEN_WIDTH-1:0] len_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [LEN_WIDTH-1:0] count_o,
   output logic                 err_o,
   fifo_burst_reader_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH,
      DONE
   } state_t;

   state_t               state_q, state_d;
   logic [LEN_WIDTH-1:0] rem_q, rem_d;
   logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
   logic                 err_q, err_d;
   logic                 pend_q, pend_d;
   logic [1:0]           occ_q, occ_d;
   logic [WIDTH-1:0]     buf0_q, buf0_d;
   logic [WIDTH-1:0]     buf1_q, buf1_d;

   logic                 pop;
   logic                 rd_en;
   logic                 busy;
   logic [1:0]           occ_pop;

   always_comb begin
      pop     = (occ_q != 2'd0) && bus.out_ready_i;
      occ_pop = occ_q - {1'b0, pop};
      busy    = (state_q == RUN) || (state_q == FLUSH);
      // Slot budget counts the word still in flight from last cycle.
      rd_en   = (state_q == RUN) && !bus.empty_i && (rem_q != '0)
                && (({1'b0, occ_pop} + {2'b00, pend_q}) < 3'd2);

      state_d = state_q;
      rem_d   = rem_q - {{(LEN_WIDTH-1){1'b0}}, rd_en};
      cnt_d   = cnt_q + {{(LEN_WIDTH-1){1'b0}}, pop};
      err_d   = err_q;
      pend_d  = rd_en;
      occ_d   = occ_pop + {1'b0, pend_q};
      buf0_d  = buf0_q;
      buf1_d  = buf1_q;

      if (pop) begin
         buf0_d = buf1_q;
      end
      if (pend_q) begin
         if (occ_pop == 2'd0) begin
            buf0_d = bus.rdata_i;
         end else begin
            buf1_d = bus.rdata_i;
         end
      end

      if (busy && bus.rd_error_i) begin
         err_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               cnt_d = '0;
               err_d = 1'b0;
               if (len_i != '0) begin
                  state_d = RUN;
                  rem_d   = len_i;
               end else begin
                  state_d = DONE;
               end
            end
         end
         RUN: begin
            if (rem_d == '0) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (!pend_q && (occ_pop == 2'd0)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         rem_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         pend_q  <= 1'b0;
         occ_q   <= 2'd0;
         buf0_q  <= '0;
         buf1_q  <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         pend_q  <= pend_d;
         occ_q   <= occ_d;
         buf0_q  <= buf0_d;
         buf1_q  <= buf1_d;
      end
   end

   assign busy_o          = busy;
   assign done_o          = (state_q == DONE);
   assign count_o         = cnt_q;
   assign err_o           = err_q;
   assign bus.rd_en_o     = rd_en;
   assign bus.out_valid_o = (occ_q != 2'd0);
   assign bus.out_data_o  = buf0_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a FIFO model and
// an output scoreboard.
module tb_fifo_burst_reader;
   localparam int W  = 8;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [LW-1:0] len;
   logic          busy, done, err;
   logic [LW-1:0] count;

   fifo_burst_reader_if #(.WIDTH(W)) bus ();

   fifo_burst_reader #(.WIDTH(W), .LEN_WIDTH(LW)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start),
      .len_i   (len),
      .busy_o  (busy),
      .done_o  (done),
      .count_o (count),
      .err_o   (err),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // FIFO model: q is written only by the stimulus, rd_ptr only here
   logic [W-1:0] q[$];
   int           wr_cnt  = 0;
   int           rd_ptr  = 0;
   logic [W-1:0] rdata_q = '0;

   always @(posedge clk) begin
      if (bus.rd_en_o && (rd_ptr < wr_cnt)) begin
         rdata_q <= q[rd_ptr];
         rd_ptr  <= rd_ptr + 1;
      end
   end

   assign bus.rdata_i = rdata_q;
   assign bus.empty_i = (rd_ptr >= wr_cnt);

   // Output monitor
   logic [W-1:0] got[$];
   int           done_cnt  = 0;
   int           rden_cnt  = 0;
   int           busy_cnt  = 0;
   logic         prev_stall = 1'b0;
   logic [W-1:0] prev_data  = '0;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (!(bus.out_valid_o && (bus.out_data_o == prev_data))) begin
               failures++;
               $display("FAIL hold_stable actual=%0b/%0h required=1/%0h",
                        bus.out_valid_o, bus.out_data_o, prev_data);
            end
         end
         prev_stall <= bus.out_valid_o && !bus.out_ready_i;
         prev_data  <= bus.out_data_o;
         if (bus.out_valid_o && bus.out_ready_i) got.push_back(bus.out_data_o);
         if (done)        done_cnt++;
         if (bus.rd_en_o) rden_cnt++;
         if (busy)        busy_cnt++;
      end
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int v);
      q.push_back(v[W-1:0]);
      wr_cnt++;
   endtask

   task automatic start_burst(input int l);
      cyc();
      start    = 1'b1;
      len      = l[LW-1:0];
      done_cnt = 0;
      rden_cnt = 0;
      busy_cnt = 0;
      got.delete();
      cyc();
      start = 1'b0;
   endtask

   task automatic wait_done(input int maxc);
      int n = 0;
      while (done_cnt == 0 && n < maxc) begin
         cyc();
         n++;
      end
      chk("done_timeout", (done_cnt != 0), 1);
      repeat (2) cyc();
   endtask

   task automatic chk_zero(input string nm);
      @(negedge clk);
      chk({nm, "_busy"},  busy, 0);
      chk({nm, "_done"},  done, 0);
      chk({nm, "_count"}, count, 0);
      chk({nm, "_err"},   err, 0);
      chk({nm, "_rden"},  bus.rd_en_o, 0);
      chk({nm, "_valid"}, bus.out_valid_o, 0);
      chk({nm, "_data"},  bus.out_data_o, 0);
   endtask

   function automatic logic rdy(input int mode, input int c);
      case (mode)
         1:       return (c % 2) == 0;
         2:       return (c % 3) != 2;
         default: return 1'b1;
      endcase
   endfunction

   typedef struct {
      int len;
      int npre;
      int mode;
      int seed;
      int exp_count;
      int exp_left;
   } vec_t;

   vec_t tbl[6];

   initial begin
      #20000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int base;
      int bad;
      int n;

      tbl[0] = '{16,  16,  1, 'h40, 16,  0};
      tbl[1] = '{5,   8,   0, 'h60, 5,   3};
      tbl[2] = '{3,   0,   2, 'h70, 3,   0};
      tbl[3] = '{1,   1,   0, 'h80, 1,   0};
      tbl[4] = '{0,   2,   0, 'h90, 0,   2};
      tbl[5] = '{255, 253, 1, 'h00, 255, 0};

      rst               = 1'b1;
      start             = 1'b0;
      len               = '0;
      bus.out_ready_i   = 1'b0;
      bus.rd_error_i    = 1'b0;

      // Power-on reset
      cyc();
      chk_zero("por");
      cyc();
      rst = 1'b0;

      // Cycle-exact full burst
      for (int i = 1; i <= 16; i++) push(i);
      bus.out_ready_i = 1'b1;
      cyc();
      start = 1'b1;
      len   = 8'd16;
      for (int k = 1; k <= 20; k++) begin
         cyc();
         if (k == 1) start = 1'b0;
         @(negedge clk);
         chk($sformatf("t2_rden_c%0d", k), bus.rd_en_o, (k <= 16));
         chk($sformatf("t2_valid_c%0d", k), bus.out_valid_o,
             (k >= 3 && k <= 18));
         if (k >= 3 && k <= 18)
            chk($sformatf("t2_data_c%0d", k), bus.out_data_o, k - 2);
         chk($sformatf("t2_done_c%0d", k), done, (k == 19));
      end
      chk("t2_count", count, 16);
      chk("t2_err", err, 0);

      // Table of bursts with different readiness patterns
      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < tbl[t].npre; i++) push((tbl[t].seed + i) % 256);
         base = rd_ptr;
         start_burst(tbl[t].len);
         n = 0;
         while (done_cnt == 0 && n < 1200) begin
            bus.out_ready_i = rdy(tbl[t].mode, n);
            cyc();
            n++;
         end
         chk($sformatf("v%0d_timeout", t), (done_cnt != 0), 1);
         bus.out_ready_i = 1'b1;
         repeat (3) cyc();
         @(negedge clk);
         chk($sformatf("v%0d_done_once", t), done_cnt, 1);
         chk($sformatf("v%0d_count", t), count, tbl[t].exp_count);
         chk($sformatf("v%0d_nwords", t), got.size(), tbl[t].exp_count);
         chk($sformatf("v%0d_reads", t), rden_cnt, tbl[t].exp_count);
         chk($sformatf("v%0d_left", t), wr_cnt - rd_ptr, tbl[t].exp_left);
         chk($sformatf("v%0d_err", t), err, 0);
         bad = 0;
         for (int i = 0; i < got.size(); i++)
            if (got[i] != q[base + i]) bad++;
         chk($sformatf("v%0d_order_bad", t), bad, 0);
         if (tbl[t].len == 0)
            chk($sformatf("v%0d_busy_cycles", t), busy_cnt, 0);
      end

      // Empty stall, then writer refills
      for (int i = 1; i <= 4; i++) push(i);
      start_burst(8);
      repeat (15) cyc();
      @(negedge clk);
      chk("t4_partial", got.size(), 4);
      chk("t4_busy", busy, 1);
      chk("t4_rden", bus.rd_en_o, 0);
      chk("t4_no_done", done_cnt, 0);
      cyc();
      for (int i = 5; i <= 8; i++) push(i);
      wait_done(50);
      @(negedge clk);
      chk("t4_count", count, 8);
      chk("t4_done_once", done_cnt, 1);
      bad = 0;
      for (int i = 0; i < 8; i++)
         if (i >= got.size() || got[i] != i + 1) bad++;
      chk("t4_order_bad", bad, 0);

      // Sticky error flag
      for (int i = 0; i < 4; i++) push('hA0 + i);
      start_burst(4);
      cyc();
      bus.rd_error_i = 1'b1;
      cyc();
      bus.rd_error_i = 1'b0;
      @(negedge clk);
      chk("err_set", err, 1);
      wait_done(50);
      @(negedge clk);
      chk("err_count", count, 4);
      chk("err_sticky", err, 1);
      push('hB0);
      start_burst(1);
      @(negedge clk);
      chk("err_cleared", err, 0);
      wait_done(50);
      bus.rd_error_i = 1'b1;
      cyc();
      bus.rd_error_i = 1'b0;
      @(negedge clk);
      chk("err_idle_ignored", err, 0);

      // Reset in the middle of a burst
      for (int i = 0; i < 16; i++) push('h21 + i);
      start_burst(16);
      n = 0;
      while (got.size() < 5 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t6_reach5", (got.size() >= 5), 1);
      cyc();
      rst = 1'b1;
      cyc();
      chk_zero("t6_rst");
      cyc();
      rst = 1'b0;
      base = rd_ptr;
      start_burst(3);
      wait_done(50);
      @(negedge clk);
      chk("t6_count", count, 3);
      chk("t6_nwords", got.size(), 3);
      bad = 0;
      for (int i = 0; i < got.size(); i++)
         if (got[i] != q[base + i]) bad++;
      chk("t6_order_bad", bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
